// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: control ops, exception codes,
// creg addresses, execution modes and the controller state enum.
package pipe_ctrl_pkg;

   localparam int CTRL_OP_W      = 2;
   localparam int ISA_EXP_W      = 3;
   localparam int CPU_EXE_MODE_W = 1;
   localparam int CREG_ADDR_W    = 5;

   localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP  = 2'd0;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_WRCR = 2'd1;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_ERET = 2'd2;
   localparam logic [CTRL_OP_W-1:0] CTRL_OP_HALT = 2'd3;

   localparam logic [ISA_EXP_W-1:0] EXP_NONE       = 3'd0;
   localparam logic [ISA_EXP_W-1:0] EXP_EXT_INT    = 3'd1;
   localparam logic [ISA_EXP_W-1:0] EXP_UNDEF_INSN = 3'd2;
   localparam logic [ISA_EXP_W-1:0] EXP_OVERFLOW   = 3'd3;
   localparam logic [ISA_EXP_W-1:0] EXP_MISS_ALIGN = 3'd4;
   localparam logic [ISA_EXP_W-1:0] EXP_PRIV_VIO   = 3'd5;

   localparam logic [CREG_ADDR_W-1:0] CREG_STATUS     = 5'd0;
   localparam logic [CREG_ADDR_W-1:0] CREG_PRE_STATUS = 5'd1;
   localparam logic [CREG_ADDR_W-1:0] CREG_EXP_CODE   = 5'd2;
   localparam logic [CREG_ADDR_W-1:0] CREG_EPC        = 5'd3;
   localparam logic [CREG_ADDR_W-1:0] CREG_INT_MASK   = 5'd4;
   localparam logic [CREG_ADDR_W-1:0] CREG_EXC_VECTOR = 5'd5;

   localparam logic [CPU_EXE_MODE_W-1:0] CPU_KERNEL = 1'b0;
   localparam logic [CPU_EXE_MODE_W-1:0] CPU_USER   = 1'b1;

   typedef enum logic {
      PIPE_STATE_RUN  = 1'b0,
      PIPE_STATE_HALT = 1'b1
   } pipe_state_e;

   // STATUS / PRE_STATUS word layout: bit1 = IE, bit0 = ExeMode.
   function automatic logic [31:0] status_word(input logic ie,
                                               input logic [CPU_EXE_MODE_W-1:0] mode);
      status_word = {30'd0, ie, mode};
   endfunction

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file: storage, exception/ERET side effects and the ID read mux.
// INT_MASK storage exists only when PIPE_CTRL_IRQ_EN is defined.
module pipe_ctrl_creg
   import pipe_ctrl_pkg::*;
#(
   parameter logic [29:0] EXC_VECTOR_INIT = 30'h0000_0040
`ifdef PIPE_CTRL_IRQ_EN
   ,
   parameter int IRQ_W = 8
`endif
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CREG_ADDR_W-1:0]    i_rd_addr,
   output logic [31:0]               o_rd_data,
   input  logic                      i_wr_en,
   input  logic [CREG_ADDR_W-1:0]    i_wr_addr,
   input  logic [31:0]               i_wr_data,
   input  logic                      i_exc_en,
   input  logic [29:0]               i_exc_epc,
   input  logic [ISA_EXP_W-1:0]      i_exc_code,
   input  logic                      i_eret_en,
   output logic                      o_ie,
   output logic [CPU_EXE_MODE_W-1:0] o_exe_mode,
   output logic [29:0]               o_epc,
`ifdef PIPE_CTRL_IRQ_EN
   output logic [IRQ_W-1:0]          o_int_mask,
`endif
   output logic [29:0]               o_exc_vector
);

   logic                      r_ie;
   logic [CPU_EXE_MODE_W-1:0] r_mode;
   logic                      r_pre_ie;
   logic [CPU_EXE_MODE_W-1:0] r_pre_mode;
   logic [ISA_EXP_W-1:0]      r_exp_code;
   logic [29:0]               r_epc;
   logic [29:0]               r_exc_vector;
`ifdef PIPE_CTRL_IRQ_EN
   logic [IRQ_W-1:0]          r_int_mask;
`endif
   logic                      w_unused_wr_hi;

   assign w_unused_wr_hi = ^i_wr_data[31:30];

   // The top raises at most one of exc/eret/wr per cycle; the order here is defensive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ie         <= 1'b0;
         r_mode       <= CPU_KERNEL;
         r_pre_ie     <= 1'b0;
         r_pre_mode   <= CPU_KERNEL;
         r_exp_code   <= EXP_NONE;
         r_epc        <= '0;
         r_exc_vector <= EXC_VECTOR_INIT;
`ifdef PIPE_CTRL_IRQ_EN
         r_int_mask   <= '1;
`endif
      end else if (i_exc_en) begin
         r_pre_ie   <= r_ie;
         r_pre_mode <= r_mode;
         r_ie       <= 1'b0;
         r_mode     <= CPU_KERNEL;
         r_epc      <= i_exc_epc;
         r_exp_code <= i_exc_code;
      end else if (i_eret_en) begin
         r_ie   <= r_pre_ie;
         r_mode <= r_pre_mode;
      end else if (i_wr_en) begin
         case (i_wr_addr)
            CREG_STATUS: begin
               r_ie   <= i_wr_data[1];
               r_mode <= i_wr_data[0];
            end
            CREG_PRE_STATUS: begin
               r_pre_ie   <= i_wr_data[1];
               r_pre_mode <= i_wr_data[0];
            end
            CREG_EXP_CODE:   r_exp_code   <= i_wr_data[ISA_EXP_W-1:0];
            CREG_EPC:        r_epc        <= i_wr_data[29:0];
`ifdef PIPE_CTRL_IRQ_EN
            CREG_INT_MASK:   r_int_mask   <= i_wr_data[IRQ_W-1:0];
`endif
            CREG_EXC_VECTOR: r_exc_vector <= i_wr_data[29:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      o_rd_data = '0;
      case (i_rd_addr)
         CREG_STATUS:     o_rd_data = status_word(r_ie, r_mode);
         CREG_PRE_STATUS: o_rd_data = status_word(r_pre_ie, r_pre_mode);
         CREG_EXP_CODE:   o_rd_data[ISA_EXP_W-1:0] = r_exp_code;
         CREG_EPC:        o_rd_data[29:0] = r_epc;
`ifdef PIPE_CTRL_IRQ_EN
         CREG_INT_MASK:   o_rd_data[IRQ_W-1:0] = r_int_mask;
`endif
         CREG_EXC_VECTOR: o_rd_data[29:0] = r_exc_vector;
         default:         o_rd_data = '0;
      endcase
   end

   assign o_ie         = r_ie;
   assign o_exe_mode   = r_mode;
   assign o_epc        = r_epc;
   assign o_exc_vector = r_exc_vector;
`ifdef PIPE_CTRL_IRQ_EN
   assign o_int_mask   = r_int_mask;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the IF/ID/EX/MEM core: stall/flush generation, MEM-stage
// event sequencing and redirect PC. Define PIPE_CTRL_IRQ_EN for interrupts and HALT wake.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [29:0] EXC_VECTOR_INIT = 30'h0000_0040,
   parameter int          IRQ_W           = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      IFBusy,
   input  logic                      MemBusy,
   input  logic                      LDHazard,
   input  logic                      MemEn,
   input  logic [29:0]               MemPC,
   input  logic [CTRL_OP_W-1:0]      MemCtrlOp,
   input  logic [ISA_EXP_W-1:0]      MemExpCode,
   input  logic [CREG_ADDR_W-1:0]    MemDstAddr,
   input  logic [31:0]               MemWrData,
   input  logic [CREG_ADDR_W-1:0]    CRegRdAddr,
   output logic [31:0]               CRegRdData,
   input  logic [IRQ_W-1:0]          Irq,
   output logic                      IFStall,
   output logic                      IDStall,
   output logic                      EXStall,
   output logic                      MemStall,
   output logic                      IFFlush,
   output logic                      IDFlush,
   output logic                      EXFlush,
   output logic                      MemFlush,
   output logic [29:0]               NewPC,
   output logic [CPU_EXE_MODE_W-1:0] ExeMode
);

   pipe_state_e          r_state;
   pipe_state_e          w_next_state;
   logic                 w_bus_stall;
   logic                 w_user;
   logic [ISA_EXP_W-1:0] w_exp_code;
   logic                 w_irq_pend;
   logic                 w_ie;
   logic [29:0]          w_epc;
   logic [29:0]          w_exc_vector;
   logic                 w_exc_en;
   logic [29:0]          w_exc_epc;
   logic [ISA_EXP_W-1:0] w_exc_code;
   logic                 w_eret_en;
   logic                 w_wr_en;
`ifdef PIPE_CTRL_IRQ_EN
   logic [IRQ_W-1:0]     w_int_mask;
   logic [29:0]          r_halt_pc;
   logic                 w_halt_enter;
`else
   logic                 w_unused_irq;
`endif

   assign w_bus_stall = IFBusy | MemBusy;
   assign w_user      = (ExeMode == CPU_USER);

   // Privileged ops in USER mode are turned into an exception before dispatch.
   always_comb begin
      w_exp_code = MemExpCode;
      if (MemExpCode == EXP_NONE && w_user &&
          (MemCtrlOp == CTRL_OP_WRCR || MemCtrlOp == CTRL_OP_ERET))
         w_exp_code = EXP_PRIV_VIO;
   end

`ifdef PIPE_CTRL_IRQ_EN
   assign w_irq_pend = (|(Irq & ~w_int_mask)) & w_ie;
`else
   assign w_irq_pend   = 1'b0;
   assign w_unused_irq = ^Irq;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= PIPE_STATE_RUN;
      else       r_state <= w_next_state;
   end

`ifdef PIPE_CTRL_IRQ_EN
   // Wake-up EPC points past the HALT so ERET resumes after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_halt_pc <= '0;
      else if (w_halt_enter) r_halt_pc <= MemPC + 30'd1;
   end
`endif

   always_comb begin
      IFStall      = 1'b0;
      IDStall      = 1'b0;
      EXStall      = 1'b0;
      MemStall     = 1'b0;
      IFFlush      = 1'b0;
      IDFlush      = 1'b0;
      EXFlush      = 1'b0;
      MemFlush     = 1'b0;
      NewPC        = '0;
      w_next_state = r_state;
      w_exc_en     = 1'b0;
      w_exc_epc    = MemPC;
      w_exc_code   = w_exp_code;
      w_eret_en    = 1'b0;
      w_wr_en      = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
      w_halt_enter = 1'b0;
`endif
      if (r_state == PIPE_STATE_HALT) begin
`ifdef PIPE_CTRL_IRQ_EN
         if (w_irq_pend && !w_bus_stall) begin
            {IFFlush, IDFlush, EXFlush, MemFlush} = 4'b1111;
            NewPC        = w_exc_vector;
            w_next_state = PIPE_STATE_RUN;
            w_exc_en     = 1'b1;
            w_exc_epc    = r_halt_pc;
            w_exc_code   = EXP_EXT_INT;
         end else begin
            {IFStall, IDStall, EXStall, MemStall} = 4'b1111;
         end
`else
         {IFStall, IDStall, EXStall, MemStall} = 4'b1111;
`endif
      end else if (w_bus_stall) begin
         {IFStall, IDStall, EXStall, MemStall} = 4'b1111;
      end else if (MemEn && (w_irq_pend || w_exp_code != EXP_NONE)) begin
         {IFFlush, IDFlush, EXFlush, MemFlush} = 4'b1111;
         NewPC      = w_exc_vector;
         w_exc_en   = 1'b1;
         w_exc_code = w_irq_pend ? EXP_EXT_INT : w_exp_code;
      end else if (MemEn && MemCtrlOp == CTRL_OP_ERET) begin
         {IFFlush, IDFlush, EXFlush, MemFlush} = 4'b1111;
         NewPC     = w_epc;
         w_eret_en = 1'b1;
      end else if (MemEn && MemCtrlOp == CTRL_OP_WRCR) begin
         {IFFlush, IDFlush, EXFlush} = 3'b111;
         NewPC   = MemPC + 30'd1;
         w_wr_en = 1'b1;
      end else if (MemEn && MemCtrlOp == CTRL_OP_HALT) begin
         {IFFlush, IDFlush, EXFlush} = 3'b111;
         NewPC        = MemPC + 30'd1;
         w_next_state = PIPE_STATE_HALT;
`ifdef PIPE_CTRL_IRQ_EN
         w_halt_enter = 1'b1;
`endif
      end else if (LDHazard) begin
         IFStall = 1'b1;
         IDFlush = 1'b1;
      end
   end

   pipe_ctrl_creg #(
      .EXC_VECTOR_INIT (EXC_VECTOR_INIT)
`ifdef PIPE_CTRL_IRQ_EN
      ,
      .IRQ_W           (IRQ_W)
`endif
   ) u_creg (
      .clk          (clk),
      .reset        (reset),
      .i_rd_addr    (CRegRdAddr),
      .o_rd_data    (CRegRdData),
      .i_wr_en      (w_wr_en),
      .i_wr_addr    (MemDstAddr),
      .i_wr_data    (MemWrData),
      .i_exc_en     (w_exc_en),
      .i_exc_epc    (w_exc_epc),
      .i_exc_code   (w_exc_code),
      .i_eret_en    (w_eret_en),
      .o_ie         (w_ie),
      .o_exe_mode   (ExeMode),
      .o_epc        (w_epc),
`ifdef PIPE_CTRL_IRQ_EN
      .o_int_mask   (w_int_mask),
`endif
      .o_exc_vector (w_exc_vector)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; covers both PIPE_CTRL_IRQ_EN builds.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        IFBusy, MemBusy, LDHazard, MemEn;
   logic [29:0] MemPC;
   logic [1:0]  MemCtrlOp;
   logic [2:0]  MemExpCode;
   logic [4:0]  MemDstAddr;
   logic [31:0] MemWrData;
   logic [4:0]  CRegRdAddr;
   logic [31:0] CRegRdData;
   logic [7:0]  Irq;
   logic        IFStall, IDStall, EXStall, MemStall;
   logic        IFFlush, IDFlush, EXFlush, MemFlush;
   logic [29:0] NewPC;
   logic [0:0]  ExeMode;
   logic [7:0]  sf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign sf = {IFStall, IDStall, EXStall, MemStall, IFFlush, IDFlush, EXFlush, MemFlush};

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .IFBusy(IFBusy), .MemBusy(MemBusy), .LDHazard(LDHazard),
      .MemEn(MemEn), .MemPC(MemPC), .MemCtrlOp(MemCtrlOp), .MemExpCode(MemExpCode),
      .MemDstAddr(MemDstAddr), .MemWrData(MemWrData), .CRegRdAddr(CRegRdAddr),
      .CRegRdData(CRegRdData), .Irq(Irq), .IFStall(IFStall), .IDStall(IDStall),
      .EXStall(EXStall), .MemStall(MemStall), .IFFlush(IFFlush), .IDFlush(IDFlush),
      .EXFlush(EXFlush), .MemFlush(MemFlush), .NewPC(NewPC), .ExeMode(ExeMode)
   );

`ifdef PIPE_CTRL_IRQ_EN
   localparam logic [31:0] MASK_RST = 32'h0000_00FF;
   localparam logic [31:0] MASK_WR  = 32'h0000_00FB;
`else
   localparam logic [31:0] MASK_RST = 32'h0;
   localparam logic [31:0] MASK_WR  = 32'h0;
`endif

   task automatic idle();
      IFBusy = 0; MemBusy = 0; LDHazard = 0; MemEn = 0; MemPC = '0;
      MemCtrlOp = CTRL_OP_NOP; MemExpCode = EXP_NONE; MemDstAddr = '0;
      MemWrData = '0; Irq = '0;
   endtask

   task automatic mem_op(input logic [29:0] pc, input logic [1:0] op, input logic [2:0] code,
                         input logic [4:0] dst, input logic [31:0] data);
      MemEn = 1; MemPC = pc; MemCtrlOp = op; MemExpCode = code;
      MemDstAddr = dst; MemWrData = data;
   endtask

   task automatic test_reset();
      logic [31:0] exp_rd [6];
      exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, MASK_RST, 32'h40};
      reset = 1; idle(); CRegRdAddr = 0;
      @(negedge clk); #1;
      n_checks++; if (sf !== 8'h00) $display("FAIL reset_sf got=%b want=00000000", sf); else n_pass++;
      n_checks++; if (NewPC !== 30'h0) $display("FAIL reset_newpc got=%h want=0", NewPC); else n_pass++;
      n_checks++; if (ExeMode !== 1'b0) $display("FAIL reset_mode got=%b want=0", ExeMode); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         CRegRdAddr = 5'(i); #1;
         n_checks++;
         if (CRegRdData !== exp_rd[i]) $display("FAIL reset_creg%0d got=%h want=%h", i, CRegRdData, exp_rd[i]);
         else n_pass++;
      end
      @(negedge clk); reset = 0;
   endtask

   task automatic test_ldhazard();
      @(negedge clk); LDHazard = 1; #1;
      n_checks++; if (sf !== 8'b1000_0100) $display("FAIL ldh_sf got=%b want=10000100", sf); else n_pass++;
      @(negedge clk); LDHazard = 0; #1;
      n_checks++; if (sf !== 8'h00) $display("FAIL ldh_after got=%b want=00000000", sf); else n_pass++;
   endtask

   task automatic test_bus_stall_exc();
      logic [31:0] exp_rd [4];
      exp_rd = '{32'h0, 32'h0, 32'h3, 32'h100};
      @(negedge clk); mem_op(30'h100, CTRL_OP_NOP, EXP_OVERFLOW, 0, 0); MemBusy = 1; CRegRdAddr = 2; #1;
      n_checks++; if (sf !== 8'b1111_0000) $display("FAIL busy_sf got=%b want=11110000", sf); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (CRegRdData !== 32'h0) $display("FAIL busy_expcode got=%h want=0", CRegRdData); else n_pass++;
      MemBusy = 0; LDHazard = 1; #1;
      n_checks++; if (sf !== 8'b0000_1111) $display("FAIL exc_sf got=%b want=00001111", sf); else n_pass++;
      n_checks++; if (NewPC !== 30'h40) $display("FAIL exc_newpc got=%h want=40", NewPC); else n_pass++;
      @(negedge clk); idle(); #1;
      n_checks++; if (ExeMode !== 1'b0) $display("FAIL exc_mode got=%b want=0", ExeMode); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         CRegRdAddr = 5'(i); #1;
         n_checks++;
         if (CRegRdData !== exp_rd[i]) $display("FAIL exc_creg%0d got=%h want=%h", i, CRegRdData, exp_rd[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wrcr_wrap();
      @(negedge clk); mem_op(30'h3FFF_FFFF, CTRL_OP_WRCR, EXP_NONE, 5, 32'h80); CRegRdAddr = 5; #1;
      n_checks++; if (NewPC !== 30'h0) $display("FAIL wrap_newpc got=%h want=0", NewPC); else n_pass++;
      n_checks++; if (sf !== 8'b0000_1110) $display("FAIL wrap_sf got=%b want=00001110", sf); else n_pass++;
      n_checks++; if (CRegRdData !== 32'h40) $display("FAIL wrap_prewrite got=%h want=40", CRegRdData); else n_pass++;
      @(negedge clk); idle(); #1;
      n_checks++; if (CRegRdData !== 32'h80) $display("FAIL wrap_vec got=%h want=80", CRegRdData); else n_pass++;
   endtask

   task automatic test_eret();
      @(negedge clk); mem_op(30'h10, CTRL_OP_WRCR, EXP_NONE, 1, 32'h3);
      @(negedge clk); mem_op(30'h11, CTRL_OP_WRCR, EXP_NONE, 3, 32'h100);
      @(negedge clk); mem_op(30'h12, CTRL_OP_ERET, EXP_NONE, 0, 0); #1;
      n_checks++; if (NewPC !== 30'h100) $display("FAIL eret_newpc got=%h want=100", NewPC); else n_pass++;
      n_checks++; if (sf !== 8'b0000_1111) $display("FAIL eret_sf got=%b want=00001111", sf); else n_pass++;
      @(negedge clk); idle(); CRegRdAddr = 0; #1;
      n_checks++; if (ExeMode !== 1'b1) $display("FAIL eret_mode got=%b want=1", ExeMode); else n_pass++;
      n_checks++; if (CRegRdData !== 32'h3) $display("FAIL eret_status got=%h want=3", CRegRdData); else n_pass++;
   endtask

   task automatic test_priv_vio();
      logic [31:0] exp_rd [6];
      exp_rd = '{32'h0, 32'h3, 32'h5, 32'h20, MASK_RST, 32'h80};
      @(negedge clk); mem_op(30'h20, CTRL_OP_WRCR, EXP_NONE, 5, 32'h55); #1;
      n_checks++; if (sf !== 8'b0000_1111) $display("FAIL priv_sf got=%b want=00001111", sf); else n_pass++;
      n_checks++; if (NewPC !== 30'h80) $display("FAIL priv_newpc got=%h want=80", NewPC); else n_pass++;
      @(negedge clk); idle(); #1;
      n_checks++; if (ExeMode !== 1'b0) $display("FAIL priv_mode got=%b want=0", ExeMode); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         CRegRdAddr = 5'(i); #1;
         n_checks++;
         if (CRegRdData !== exp_rd[i]) $display("FAIL priv_creg%0d got=%h want=%h", i, CRegRdData, exp_rd[i]);
         else n_pass++;
      end
   endtask

   task automatic test_unmapped_and_setup();
      @(negedge clk); mem_op(30'h30, CTRL_OP_WRCR, EXP_NONE, 9, 32'hFFFF_FFFF); CRegRdAddr = 9; #1;
      n_checks++; if (NewPC !== 30'h31) $display("FAIL unmap_newpc got=%h want=31", NewPC); else n_pass++;
      @(negedge clk); mem_op(30'h31, CTRL_OP_WRCR, EXP_NONE, 4, 32'hFB); #1;
      n_checks++; if (CRegRdData !== 32'h0) $display("FAIL unmap_rd got=%h want=0", CRegRdData); else n_pass++;
      @(negedge clk); mem_op(30'h32, CTRL_OP_WRCR, EXP_NONE, 0, 32'h2);
      @(negedge clk); idle(); CRegRdAddr = 4; #1;
      n_checks++; if (CRegRdData !== MASK_WR) $display("FAIL mask_rd got=%h want=%h", CRegRdData, MASK_WR); else n_pass++;
      CRegRdAddr = 0; #1;
      n_checks++; if (CRegRdData !== 32'h2) $display("FAIL ie_set got=%h want=2", CRegRdData); else n_pass++;
   endtask

   task automatic test_halt();
      @(negedge clk); mem_op(30'h200, CTRL_OP_HALT, EXP_NONE, 0, 0); #1;
      n_checks++; if (sf !== 8'b0000_1110) $display("FAIL halt_sf got=%b want=00001110", sf); else n_pass++;
      n_checks++; if (NewPC !== 30'h201) $display("FAIL halt_newpc got=%h want=201", NewPC); else n_pass++;
      @(negedge clk); mem_op(30'h201, CTRL_OP_NOP, EXP_OVERFLOW, 0, 0); LDHazard = 1; #1;
      n_checks++; if (sf !== 8'b1111_0000) $display("FAIL halted_sf got=%b want=11110000", sf); else n_pass++;
      @(negedge clk); idle(); Irq = 8'h04; #1;
`ifdef PIPE_CTRL_IRQ_EN
      n_checks++; if (sf !== 8'b0000_1111) $display("FAIL wake_sf got=%b want=00001111", sf); else n_pass++;
      n_checks++; if (NewPC !== 30'h80) $display("FAIL wake_newpc got=%h want=80", NewPC); else n_pass++;
      @(negedge clk); Irq = 0; CRegRdAddr = 2; #1;
      n_checks++; if (CRegRdData !== 32'h1) $display("FAIL wake_expcode got=%h want=1", CRegRdData); else n_pass++;
      CRegRdAddr = 3; #1;
      n_checks++; if (CRegRdData !== 32'h201) $display("FAIL wake_epc got=%h want=201", CRegRdData); else n_pass++;
      n_checks++; if (sf !== 8'h00) $display("FAIL wake_run got=%b want=00000000", sf); else n_pass++;
`else
      n_checks++; if (sf !== 8'b1111_0000) $display("FAIL noirq_sf got=%b want=11110000", sf); else n_pass++;
      @(negedge clk); CRegRdAddr = 2; #1;
      n_checks++; if (CRegRdData !== 32'h5) $display("FAIL noirq_expcode got=%h want=5", CRegRdData); else n_pass++;
      n_checks++; if (sf !== 8'b1111_0000) $display("FAIL noirq_stay got=%b want=11110000", sf); else n_pass++;
`endif
   endtask

   task automatic test_reset_abort();
`ifdef PIPE_CTRL_IRQ_EN
      @(negedge clk); mem_op(30'h300, CTRL_OP_HALT, EXP_NONE, 0, 0);
      @(negedge clk); idle(); #1;
      n_checks++; if (sf !== 8'b1111_0000) $display("FAIL rehalt_sf got=%b want=11110000", sf); else n_pass++;
`endif
      reset = 1; CRegRdAddr = 5; #1;
      n_checks++; if (sf !== 8'h00) $display("FAIL abort_sf got=%b want=00000000", sf); else n_pass++;
      n_checks++; if (CRegRdData !== 32'h40) $display("FAIL abort_vec got=%h want=40", CRegRdData); else n_pass++;
      @(negedge clk); reset = 0;
      @(negedge clk); LDHazard = 1; #1;
      n_checks++; if (sf !== 8'b1000_0100) $display("FAIL abort_run got=%b want=10000100", sf); else n_pass++;
      @(negedge clk); idle();
   endtask

   initial begin
      test_reset();
      test_ldhazard();
      test_bus_stall_exc();
      test_wrcr_wrap();
      test_eret();
      test_priv_vio();
      test_unmapped_and_setup();
      test_halt();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
